// File: rtl/ula_pkg.sv
// Shared types for the ALU result path: op codes, buffered entry layout
// and buffer occupancy states.
package ula_pkg;
   parameter int numeroBits = 8;

   typedef enum logic [1:0] {OP_AND, OP_OR, OP_ADD, OP_SUB} op_t;

   typedef struct packed {
      logic signed [numeroBits-1:0] saida;
      logic                         flag;
      op_t                          op;
   } entrada_t;

   typedef enum logic [1:0] {VAZIO = 2'd0, UM = 2'd1, CHEIO = 2'd2} ocupacao_t;
endpackage

// File: rtl/buffer_saida.sv
// Generic 2-entry FIFO of entrada_t. When empty, the head shows the last
// popped entry so downstream data holds its value.
module buffer_saida
   import ula_pkg::*;
#(
   parameter int PROFUNDIDADE = 2
) (
   input  logic     clk,
   input  logic     reset,
   input  logic     i_push,
   input  logic     i_pop,
   input  entrada_t i_dado,
   output entrada_t o_dado,
   output logic     o_full,
   output logic     o_empty
);
   entrada_t  r_mem [PROFUNDIDADE];
   entrada_t  r_ultimo;
   logic      r_wr;
   logic      r_rd;
   ocupacao_t r_estado;
   ocupacao_t w_estado_n;
   logic      w_push;
   logic      w_pop;

   assign o_full  = (r_estado == CHEIO);
   assign o_empty = (r_estado == VAZIO);
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_dado  = o_empty ? r_ultimo : r_mem[r_rd];

   always_ff @(posedge clk) begin
      if (reset) r_estado <= VAZIO;
      else       r_estado <= w_estado_n;
   end

   always_comb begin
      w_estado_n = r_estado;
      case (r_estado)
         VAZIO:   if (w_push) w_estado_n = UM;
         UM: begin
            if (w_push && !w_pop)      w_estado_n = CHEIO;
            else if (w_pop && !w_push) w_estado_n = VAZIO;
         end
         CHEIO:   if (w_pop) w_estado_n = UM;
         default: w_estado_n = VAZIO;
      endcase
   end

   // 1-bit pointers wrap naturally modulo the depth of 2
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr     <= 1'b0;
         r_rd     <= 1'b0;
         r_ultimo <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr] <= i_dado;
            r_wr        <= r_wr + 1'b1;
         end
         if (w_pop) begin
            r_ultimo <= r_mem[r_rd];
            r_rd     <= r_rd + 1'b1;
         end
      end
   end
endmodule

// File: rtl/registrador_resultado.sv
// ALU result stage: flag masking, zero/neg status, sticky overflow and an
// overflow event counter present only when REG_RESULTADO_CONTADOR_EN is defined.
module registrador_resultado
   import ula_pkg::*;
#(
   parameter int PROFUNDIDADE = 2,
   parameter int LARGURA_CONT = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic signed [numeroBits-1:0] in_saida,
   input  logic                         in_flag,
   input  logic [1:0]                   in_op,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic signed [numeroBits-1:0] out_saida,
   output logic                         out_flag,
   output logic [1:0]                   out_op,
   output logic                         out_zero,
   output logic                         out_neg,
   input  logic                         clr_flag,
   output logic                         sticky_ovf,
   output logic [LARGURA_CONT-1:0]      cont_ovf
);
   logic     w_push;
   logic     w_pop;
   logic     w_full;
   logic     w_empty;
   logic     w_flag_mask;
   logic     w_evento;
   entrada_t w_ent;
   entrada_t w_head;
   logic     r_sticky;

   // Only arithmetic ops (op[1]=1) can overflow; logic ops never store a flag
   assign w_flag_mask = in_flag && in_op[1];
   assign w_ent       = '{saida: in_saida, flag: w_flag_mask, op: op_t'(in_op)};

   assign in_ready  = !reset && !w_full;
   assign out_valid = !w_empty;
   assign w_push    = in_valid && in_ready;
   assign w_pop     = out_valid && out_ready;
   assign w_evento  = w_push && w_flag_mask;

   buffer_saida #(.PROFUNDIDADE(PROFUNDIDADE)) u_buf (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_dado  (w_ent),
      .o_dado  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign out_saida = w_head.saida;
   assign out_flag  = w_head.flag;
   assign out_op    = w_head.op;
   assign out_zero  = out_valid && (w_head.saida == '0);
   assign out_neg   = out_valid && w_head.saida[numeroBits-1];

   // Set has priority over clear
   always_ff @(posedge clk) begin
      if (reset)         r_sticky <= 1'b0;
      else if (w_evento) r_sticky <= 1'b1;
      else if (clr_flag) r_sticky <= 1'b0;
   end
   assign sticky_ovf = r_sticky;

`ifdef REG_RESULTADO_CONTADOR_EN
   localparam logic [LARGURA_CONT-1:0] CONT_MAX = '1;
   logic [LARGURA_CONT-1:0] r_cont;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cont <= '0;
      end else if (w_evento) begin
         if (clr_flag)              r_cont <= LARGURA_CONT'(1);
         else if (r_cont != CONT_MAX) r_cont <= r_cont + 1'b1;
      end else if (clr_flag) begin
         r_cont <= '0;
      end
   end
   assign cont_ovf = r_cont;
`else
   assign cont_ovf = '0;
`endif
endmodule

// File: tb/tb_registrador_resultado.sv
// Bench for registrador_resultado: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_registrador_resultado;
   typedef struct packed {
      logic [7:0] s;
      logic       f;
      logic [1:0] o;
   } ent_t;

`ifdef REG_RESULTADO_CONTADOR_EN
   localparam int HAS_CNT = 1;
`else
   localparam int HAS_CNT = 0;
`endif
   localparam int CMAX = 255;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic signed [7:0] in_saida = '0;
   logic              in_flag = 1'b0;
   logic [1:0]        in_op = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic signed [7:0] out_saida;
   logic              out_flag;
   logic [1:0]        out_op;
   logic              out_zero;
   logic              out_neg;
   logic              clr_flag = 1'b0;
   logic              sticky_ovf;
   logic [7:0]        cont_ovf;

   int n_checks = 0;
   int n_err = 0;

   ent_t q[$];
   ent_t m_last = '0;
   bit   m_sticky = 0;
   int   m_cnt = 0;

   registrador_resultado dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_saida(in_saida), .in_flag(in_flag), .in_op(in_op),
      .out_valid(out_valid), .out_ready(out_ready), .out_saida(out_saida),
      .out_flag(out_flag), .out_op(out_op), .out_zero(out_zero), .out_neg(out_neg),
      .clr_flag(clr_flag), .sticky_ovf(sticky_ovf), .cont_ovf(cont_ovf)
   );

   always #5 clk = ~clk;

   // Reference model: a queue of at most two entries, advanced at each edge
   function automatic void model_step();
      bit   rdy, push, pop, mf;
      ent_t e;
      rdy  = !reset && (q.size() < 2);
      push = in_valid && rdy;
      pop  = (q.size() > 0) && out_ready;
      mf   = in_flag && in_op[1];
      if (reset) begin
         q.delete();
         m_last = '0; m_sticky = 0; m_cnt = 0;
      end else begin
         if (pop) m_last = q.pop_front();
         if (push) begin
            e.s = in_saida; e.f = mf; e.o = in_op;
            q.push_back(e);
         end
         if (push && mf) begin
            m_sticky = 1;
            m_cnt = clr_flag ? 1 : (m_cnt < CMAX ? m_cnt + 1 : m_cnt);
         end else if (clr_flag) begin
            m_sticky = 0; m_cnt = 0;
         end
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      reset = 1; in_valid = 0; out_ready = 0; clr_flag = 0;
      tick();
      reset = 0; #1;
   endtask

   task automatic test_reset();
      reset = 1; in_valid = 1; out_ready = 0;
      tick(); tick();
      n_checks++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b exp 0", in_ready); end
      in_valid = 0; reset = 0; #1;
      n_checks++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready_after: got %b exp 1", in_ready); end
      n_checks++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b exp 0", out_valid); end
      n_checks++; if ({out_saida, out_flag, out_op} !== 11'd0) begin n_err++; $display("FAIL rst_data: got %h/%b/%h exp 0", out_saida, out_flag, out_op); end
      n_checks++; if ({sticky_ovf, cont_ovf} !== 9'd0) begin n_err++; $display("FAIL rst_ovf: got %b/%0d exp 0/0", sticky_ovf, cont_ovf); end
   endtask

   task automatic test_single_push();
      do_reset();
      in_valid = 1; in_op = 2'b10; in_saida = -8'sd106; in_flag = 1;
      tick();
      in_valid = 0; in_flag = 0;
      n_checks++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL push_valid: got %b exp 1", out_valid); end
      n_checks++; if (out_saida !== -8'sd106) begin n_err++; $display("FAIL push_saida: got %0d exp -106", out_saida); end
      n_checks++; if ({out_flag, out_neg, out_zero, out_op} !== 5'b11010) begin n_err++; $display("FAIL push_status: got f%b n%b z%b op%b exp f1 n1 z0 op10", out_flag, out_neg, out_zero, out_op); end
      n_checks++; if (sticky_ovf !== 1'b1) begin n_err++; $display("FAIL push_sticky: got %b exp 1", sticky_ovf); end
      n_checks++; if (cont_ovf !== 8'(HAS_CNT)) begin n_err++; $display("FAIL push_cont: got %0d exp %0d", cont_ovf, HAS_CNT); end
      out_ready = 1; tick(); out_ready = 0;
      n_checks++; if ({out_valid, out_neg} !== 2'b00 || out_saida !== -8'sd106) begin n_err++; $display("FAIL pop_hold: got v%b n%b d%0d exp v0 n0 d-106", out_valid, out_neg, out_saida); end
   endtask

   task automatic test_masking();
      do_reset();
      in_valid = 1; in_op = 2'b01; in_saida = 0; in_flag = 1;
      tick();
      in_valid = 0; in_flag = 0;
      n_checks++; if ({out_valid, out_flag, out_zero} !== 3'b101) begin n_err++; $display("FAIL mask: got v%b f%b z%b exp v1 f0 z1", out_valid, out_flag, out_zero); end
      n_checks++; if ({sticky_ovf, cont_ovf} !== 9'd0) begin n_err++; $display("FAIL mask_sticky: got %b/%0d exp 0/0", sticky_ovf, cont_ovf); end
      out_ready = 1; tick(); out_ready = 0;
   endtask

   task automatic test_backpressure();
      do_reset();
      in_op = 2'b00; in_flag = 0; out_ready = 0;
      in_valid = 1; in_saida = 5; tick();
      in_saida = 7; tick();
      n_checks++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full: got %b exp 0", in_ready); end
      in_saida = 9; tick();
      in_valid = 0;
      n_checks++; if (out_saida !== 8'sd5) begin n_err++; $display("FAIL bp_head_stable: got %0d exp 5", out_saida); end
      out_ready = 1; tick();
      n_checks++; if (out_valid !== 1'b1 || out_saida !== 8'sd7) begin n_err++; $display("FAIL bp_second: got v%b d%0d exp v1 d7", out_valid, out_saida); end
      tick();
      n_checks++; if ({out_valid, in_ready} !== 2'b01) begin n_err++; $display("FAIL bp_drain: got v%b r%b exp v0 r1", out_valid, in_ready); end
      out_ready = 0;
   endtask

   task automatic test_push_pop();
      do_reset();
      in_op = 2'b10; in_flag = 0;
      in_valid = 1; in_saida = 11; tick();
      out_ready = 1; in_saida = 22; tick();
      n_checks++; if ({out_valid, in_ready} !== 2'b11 || out_saida !== 8'sd22) begin n_err++; $display("FAIL pp_first: got v%b r%b d%0d exp v1 r1 d22", out_valid, in_ready, out_saida); end
      in_saida = 33; tick();
      n_checks++; if ({out_valid, in_ready} !== 2'b11 || out_saida !== 8'sd33) begin n_err++; $display("FAIL pp_second: got v%b r%b d%0d exp v1 r1 d33", out_valid, in_ready, out_saida); end
      in_valid = 0; tick();
      n_checks++; if (out_valid !== 1'b0 || out_saida !== 8'sd33) begin n_err++; $display("FAIL pp_drain: got v%b d%0d exp v0 d33", out_valid, out_saida); end
      out_ready = 0;
   endtask

   task automatic test_clr_flag();
      do_reset();
      out_ready = 1;
      in_valid = 1; in_op = 2'b11; in_saida = 8'sh6A; in_flag = 1; clr_flag = 1;
      tick();
      in_valid = 0; in_flag = 0;
      n_checks++; if (sticky_ovf !== 1'b1 || cont_ovf !== 8'(HAS_CNT)) begin n_err++; $display("FAIL clr_set_wins: got %b/%0d exp 1/%0d", sticky_ovf, cont_ovf, HAS_CNT); end
      tick();
      clr_flag = 0;
      n_checks++; if ({sticky_ovf, cont_ovf} !== 9'd0) begin n_err++; $display("FAIL clr_alone: got %b/%0d exp 0/0", sticky_ovf, cont_ovf); end
      out_ready = 0;
   endtask

   task automatic test_saturation();
      do_reset();
      out_ready = 1; in_valid = 1; in_op = 2'b10; in_flag = 1;
      for (int i = 0; i < 260; i++) begin
         in_saida = 8'($urandom);
         tick();
      end
      n_checks++; if (cont_ovf !== 8'(HAS_CNT * 255) || sticky_ovf !== 1'b1) begin n_err++; $display("FAIL sat: got %0d/%b exp %0d/1", cont_ovf, sticky_ovf, HAS_CNT * 255); end
      out_ready = 0; tick(); tick();
      n_checks++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL sat_full: got %b exp 0", in_ready); end
      in_valid = 0; in_flag = 0; reset = 1; tick();
      n_checks++; if ({out_valid, out_saida, out_flag, out_op, out_zero, out_neg, sticky_ovf, cont_ovf, in_ready} !== 24'd0) begin
         n_err++; $display("FAIL rst_full: got v%b d%h f%b op%b z%b n%b s%b c%0d r%b exp all 0", out_valid, out_saida, out_flag, out_op, out_zero, out_neg, sticky_ovf, cont_ovf, in_ready);
      end
      reset = 0; #1;
   endtask

   task automatic test_random();
      ent_t h;
      int   ev;
      for (int i = 0; i < 600; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         in_saida  = 8'($urandom);
         in_flag   = 1'($urandom);
         in_op     = 2'($urandom);
         clr_flag  = ($urandom_range(0, 7) == 0);
         reset     = ($urandom_range(0, 63) == 0);
         tick();
         h  = (q.size() > 0) ? q[0] : m_last;
         ev = HAS_CNT ? m_cnt : 0;
         n_checks++;
         if (out_valid !== (q.size() > 0) || in_ready !== (!reset && q.size() < 2) ||
             {out_saida, out_flag, out_op} !== h ||
             out_zero !== (q.size() > 0 && h.s == 0) || out_neg !== (q.size() > 0 && h.s[7]) ||
             sticky_ovf !== m_sticky || cont_ovf !== 8'(ev)) begin
            n_err++;
            $display("FAIL rand[%0d]: got v%b r%b d%h f%b op%b z%b n%b s%b c%0d exp v%b d%h f%b op%b s%b c%0d",
                     i, out_valid, in_ready, out_saida, out_flag, out_op, out_zero, out_neg, sticky_ovf, cont_ovf,
                     q.size() > 0, h.s, h.f, h.o, m_sticky, ev);
         end
      end
      reset = 0; in_valid = 0; out_ready = 0; clr_flag = 0;
   endtask

   initial begin
      test_reset();
      test_single_push();
      test_masking();
      test_backpressure();
      test_push_pop();
      test_clr_flag();
      test_saturation();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule

// File: doc/registrador_resultado.md
Name: registrador_resultado

Overview:
- Downstream stage of the 8-bit signed ALU. Captures each ALU result (Saida), overflow Flag and op code F into a 2-entry output buffer using a valid/ready handshake.
- Presents registered results to the next consumer (register file or display), together with derived zero/negative status.
- Maintains a sticky overflow indicator and an optional saturating overflow event counter.

Parameters:
- numeroBits, 8, data width of the result path; must match the ALU.
- PROFUNDIDADE, 2, buffer depth in entries; fixed at 2, and the pointer width is 1 bit.
- LARGURA_CONT, 8, width of the overflow event counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  ALU result is valid this cycle.
- in_ready  output  1  stage can accept an entry; equals not-full, forced 0 while reset is high.
- in_saida  input  numeroBits  signed ALU result (Saida).
- in_flag  input  1  ALU overflow Flag.
- in_op  input  2  ALU op code F (00 AND, 01 OR, 10 ADD, 11 SUB).
- out_valid  output  1  buffer head holds a valid entry.
- out_ready  input  1  consumer accepts the head entry.
- out_saida  output  numeroBits  signed head result.
- out_flag  output  1  head overflow flag, after masking.
- out_op  output  2  head op code.
- out_zero  output  1  high when out_valid and out_saida == 0.
- out_neg  output  1  high when out_valid and out_saida[msb] == 1.
- clr_flag  input  1  clears the sticky flag and the counter.
- sticky_ovf  output  1  set on any accepted masked overflow.
- cont_ovf  output  LARGURA_CONT  count of accepted overflow entries.

Behaviour:
- Reset, synchronous: buffer emptied, pointers and occupancy set to 0, out_valid=0, out_saida=0, out_flag=0, out_op=0, sticky_ovf=0, cont_ovf=0.
- Reset asserted mid-operation flushes all entries on that edge. Entries in flight are lost. in_ready=0 during reset and 1 on the first cycle after reset.
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- Occupancy states: VAZIO (0), UM (1), CHEIO (2).
  - VAZIO + push -> UM.
  - UM + push without pop -> CHEIO.
  - UM + pop without push -> VAZIO.
  - UM + push and pop -> UM.
  - CHEIO + pop -> UM.
- in_ready = (occupancy != CHEIO). It is computed from registered state only, so there is no combinational path from out_ready to in_ready.
- Latency: an entry pushed in cycle N appears at the head with out_valid=1 in cycle N+1 if the buffer was empty. Data is otherwise delivered in FIFO order.
- Head outputs stay stable while out_valid && !out_ready.
- Output data when out_valid=0: out_saida, out_flag and out_op hold their last values; out_zero and out_neg read 0.
- Flag masking: the captured flag equals in_flag && in_op[1]. Logic ops (AND, OR) never store a flag.
- Sticky flag: on a push with masked flag 1, sticky_ovf becomes 1. clr_flag clears it. If clr_flag and a flagged push happen in the same cycle, set wins: sticky_ovf=1 and the counter becomes 1.
- Counter: increments by 1 on each flagged push and saturates at 2^LARGURA_CONT-1 (no wrap). clr_flag without a flagged push resets it to 0.
- Pointer arithmetic: rd and wr pointers wrap modulo PROFUNDIDADE.
- Data is treated as signed; out_neg comes from the MSB only.

Optional Feature:
- REG_RESULTADO_CONTADOR_EN defined: cont_ovf is implemented as specified.
- REG_RESULTADO_CONTADOR_EN undefined: no counter register is synthesized and cont_ovf is tied to 0. sticky_ovf behaviour is unchanged.

Decomposition:
- Package ula_pkg holds:
  - parameter numeroBits = 8;
  - typedef enum logic [1:0] op_t {OP_AND, OP_OR, OP_ADD, OP_SUB};
  - packed struct entrada_t {saida, flag, op};
  - typedef enum for the occupancy states VAZIO/UM/CHEIO.
- One natural sub-module, buffer_saida: a generic 2-entry FIFO of entrada_t with push/pop/full/empty. registrador_resultado adds masking, status derivation, sticky flag and counter around it.

Test Plan:
- Reset, then a single push: in_op=ADD, in_saida=-106 (100+50 overflow), in_flag=1. Required: next cycle out_valid=1, out_saida=-106, out_flag=1, out_neg=1, sticky_ovf=1, cont_ovf=1.
- Masking: push in_op=OR, in_flag=1, in_saida=0. Required: out_flag=0, out_zero=1, sticky_ovf unchanged at 0.
- Backpressure: out_ready=0, push 5 then 7. Required: in_ready=0 after the second push and a third push is ignored. Then raise out_ready: required 5 then 7 on consecutive cycles, after which in_ready=1.
- Simultaneous push and pop with one entry held: required occupancy stays UM, FIFO order is kept, and no entry is lost or duplicated.
- clr_flag in the same cycle as a flagged SUB push (-100-50). Required: sticky_ovf=1, cont_ovf=1. A later clr_flag alone gives 0/0.
- Saturation (with REG_RESULTADO_CONTADOR_EN defined): 260 flagged pushes give cont_ovf=255. Reset asserted while CHEIO: next cycle out_valid=0 and all outputs are 0.
